// File: rtl/shift_reg_n.sv
// shift_reg_n : parametrised universal shift register with self-timed burst.
//
// Ports
//   clock          rising-edge clock, sole clock domain
//   reset          synchronous active-high reset, overrides everything
//   enable         clock enable for mode operations and burst shifting
//   mode[2:0]      idle-time operation select (hold/shr/shl/ror/rol/load)
//   shift_in       serial input bit (MSB side on right shifts, LSB on left)
//   load_data      parallel load word / burst source word
//   start          burst request, sampled only while idle
//   q              register contents
//   shift_out_lsb  q[0]
//   shift_out_msb  q[WIDTH-1]
//   busy           registered, high while a burst is in progress
//   done           registered one-cycle pulse on the first idle cycle
//                  after a burst's final shift
module shift_reg_n #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [2:0]       mode,
  input  logic             shift_in,
  input  logic [WIDTH-1:0] load_data,
  input  logic             start,
  output logic [WIDTH-1:0] q,
  output logic             shift_out_lsb,
  output logic             shift_out_msb,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_SHR  = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_ROR  = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_LOAD = 3'b101;

  typedef enum logic {IDLE, BURST} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // A burst request wins over any mode operation and ignores enable.
        if (start) begin
          q_d     = load_data;
          cnt_d   = CW'(WIDTH);
          state_d = BURST;
        end else if (enable) begin
          case (mode)
            M_HOLD:  q_d = q_q;
            M_SHR:   q_d = {shift_in, q_q[WIDTH-1:1]};
            M_SHL:   q_d = {q_q[WIDTH-2:0], shift_in};
            M_ROR:   q_d = {q_q[0], q_q[WIDTH-1:1]};
            M_ROL:   q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            M_LOAD:  q_d = load_data;
            default: q_d = q_q;  // reserved codes hold
          endcase
        end
      end
      BURST: begin
        // Stalls (enable=0) freeze both data and count; no timeout.
        if (enable) begin
          q_d   = {shift_in, q_q[WIDTH-1:1]};
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == BURST);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      q_q     <= RESET_VALUE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign q             = q_q;
  assign shift_out_lsb = q_q[0];
  assign shift_out_msb = q_q[WIDTH-1];
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_shift_reg_n.sv
// Bench for shift_reg_n: a WIDTH=4 instance for the main scenarios and a
// WIDTH=8, RESET_VALUE=A5 instance for back-to-back bursts. Stimulus steps
// push the expected post-edge state into a scoreboard queue; a monitor pops
// one entry per clock edge and compares.
module tb_shift_reg_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=4 instance signals
  logic       rst4 = 1'b1, en4 = 1'b0, si4 = 1'b0, st4 = 1'b0;
  logic [2:0] md4 = 3'b000;
  logic [3:0] ld4 = '0, q4;
  logic       lsb4, msb4, busy4, done4;

  // WIDTH=8 instance signals
  logic       rst8 = 1'b1, en8 = 1'b0, si8 = 1'b0, st8 = 1'b0;
  logic [2:0] md8 = 3'b000;
  logic [7:0] ld8 = '0, q8;
  logic       lsb8, msb8, busy8, done8;

  shift_reg_n #(.WIDTH(4), .RESET_VALUE(4'h0)) u_dut4 (
    .clock(clk), .reset(rst4), .enable(en4), .mode(md4), .shift_in(si4),
    .load_data(ld4), .start(st4), .q(q4), .shift_out_lsb(lsb4),
    .shift_out_msb(msb4), .busy(busy4), .done(done4)
  );

  shift_reg_n #(.WIDTH(8), .RESET_VALUE(8'hA5)) u_dut8 (
    .clock(clk), .reset(rst8), .enable(en8), .mode(md8), .shift_in(si8),
    .load_data(ld8), .start(st8), .q(q8), .shift_out_lsb(lsb8),
    .shift_out_msb(msb8), .busy(busy8), .done(done8)
  );

  typedef struct {
    string      tag;
    bit         wide;
    logic [7:0] q;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step4(input string tag, input logic rst, input logic en,
                       input logic [2:0] md, input logic si, input logic [3:0] ld,
                       input logic st, input logic [3:0] eq, input logic eb,
                       input logic ed);
    exp_t e;
    @(negedge clk);
    rst4 = rst; en4 = en; md4 = md; si4 = si; ld4 = ld; st4 = st;
    e.tag = tag; e.wide = 1'b0; e.q = {4'h0, eq}; e.busy = eb; e.done = ed;
    sb.push_back(e);
  endtask

  task automatic step8(input string tag, input logic rst, input logic en,
                       input logic si, input logic [7:0] ld, input logic st,
                       input logic [7:0] eq, input logic eb, input logic ed);
    exp_t e;
    @(negedge clk);
    rst8 = rst; en8 = en; md8 = 3'b000; si8 = si; ld8 = ld; st8 = st;
    e.tag = tag; e.wide = 1'b1; e.q = eq; e.busy = eb; e.done = ed;
    sb.push_back(e);
  endtask

  // Monitor: one expected entry per clock edge, sampled 1 time unit after.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (!e.wide) begin
          chk({e.tag, "_q"},    32'(q4),    32'(e.q[3:0]));
          chk({e.tag, "_lsb"},  32'(lsb4),  32'(e.q[0]));
          chk({e.tag, "_msb"},  32'(msb4),  32'(e.q[3]));
          chk({e.tag, "_busy"}, 32'(busy4), 32'(e.busy));
          chk({e.tag, "_done"}, 32'(done4), 32'(e.done));
        end else begin
          chk({e.tag, "_q"},    32'(q8),    32'(e.q));
          chk({e.tag, "_lsb"},  32'(lsb8),  32'(e.q[0]));
          chk({e.tag, "_msb"},  32'(msb8),  32'(e.q[7]));
          chk({e.tag, "_busy"}, 32'(busy8), 32'(e.busy));
          chk({e.tag, "_done"}, 32'(done8), 32'(e.done));
        end
      end
    end
  end

  initial begin
    logic [7:0] w;
    //           tag     rst en mode    si ld     st  q       busy done
    // 1: serial shift right
    step4("t1_rst",  1, 0, 3'b000, 0, 4'h0, 0, 4'b0000, 0, 0);
    step4("t1_s1",   0, 1, 3'b001, 1, 4'h0, 0, 4'b1000, 0, 0);
    step4("t1_s2",   0, 1, 3'b001, 0, 4'h0, 0, 4'b0100, 0, 0);
    step4("t1_s3",   0, 1, 3'b001, 0, 4'h0, 0, 4'b0010, 0, 0);
    step4("t1_s4",   0, 1, 3'b001, 0, 4'h0, 0, 4'b0001, 0, 0);
    step4("t1_s5",   0, 1, 3'b001, 0, 4'h0, 0, 4'b0000, 0, 0);
    // 2: load, rotate right x4, rotate left
    step4("t2_ld",   0, 1, 3'b101, 0, 4'hB, 0, 4'b1011, 0, 0);
    step4("t2_ror1", 0, 1, 3'b011, 0, 4'h0, 0, 4'b1101, 0, 0);
    step4("t2_ror2", 0, 1, 3'b011, 0, 4'h0, 0, 4'b1110, 0, 0);
    step4("t2_ror3", 0, 1, 3'b011, 0, 4'h0, 0, 4'b0111, 0, 0);
    step4("t2_ror4", 0, 1, 3'b011, 0, 4'h0, 0, 4'b1011, 0, 0);
    step4("t2_rol",  0, 1, 3'b100, 1, 4'h0, 0, 4'b0111, 0, 0);
    // holds: reserved mode, enable low, explicit hold
    step4("t2_rsv",  0, 1, 3'b110, 1, 4'hF, 0, 4'b0111, 0, 0);
    step4("t2_rsv7", 0, 1, 3'b111, 1, 4'hF, 0, 4'b0111, 0, 0);
    step4("t2_en0",  0, 0, 3'b101, 1, 4'hF, 0, 4'b0111, 0, 0);
    step4("t2_hold", 0, 1, 3'b000, 1, 4'hF, 0, 4'b0111, 0, 0);
    // shift left brings shift_in into the LSB
    step4("t2_shl",  0, 1, 3'b010, 1, 4'h0, 0, 4'b1111, 0, 0);
    step4("t2_shl0", 0, 1, 3'b010, 0, 4'h0, 0, 4'b1110, 0, 0);
    // 3: plain burst, start captured even with enable low
    step4("t3_st",   0, 0, 3'b001, 0, 4'hA, 1, 4'b1010, 1, 0);
    step4("t3_b1",   0, 1, 3'b000, 0, 4'h0, 0, 4'b0101, 1, 0);
    step4("t3_b2",   0, 1, 3'b000, 0, 4'h0, 0, 4'b0010, 1, 0);
    step4("t3_b3",   0, 1, 3'b000, 0, 4'h0, 0, 4'b0001, 1, 0);
    step4("t3_b4",   0, 1, 3'b000, 0, 4'h0, 0, 4'b0000, 0, 1);
    step4("t3_idle", 0, 0, 3'b000, 0, 4'h0, 0, 4'b0000, 0, 0);
    // 4: burst with two stall cycles; mode/start during burst ignored
    step4("t4_st",   0, 1, 3'b000, 0, 4'hA, 1, 4'b1010, 1, 0);
    step4("t4_b1",   0, 1, 3'b000, 1, 4'h0, 0, 4'b1101, 1, 0);
    step4("t4_stl1", 0, 0, 3'b101, 0, 4'hF, 0, 4'b1101, 1, 0);
    step4("t4_stl2", 0, 0, 3'b101, 0, 4'hF, 1, 4'b1101, 1, 0);
    step4("t4_b2",   0, 1, 3'b101, 0, 4'hF, 0, 4'b0110, 1, 0);
    step4("t4_b3",   0, 1, 3'b010, 1, 4'h0, 0, 4'b1011, 1, 0);
    step4("t4_b4",   0, 1, 3'b000, 1, 4'h0, 0, 4'b1101, 0, 1);
    step4("t4_idle", 0, 0, 3'b000, 0, 4'h0, 0, 4'b1101, 0, 0);
    // 5: reset mid-burst, start with reset ignored, then fresh burst
    step4("t5_st",   0, 1, 3'b000, 0, 4'h6, 1, 4'b0110, 1, 0);
    step4("t5_rst",  1, 1, 3'b000, 0, 4'h0, 0, 4'b0000, 0, 0);
    step4("t5_nodn", 0, 0, 3'b000, 0, 4'h0, 0, 4'b0000, 0, 0);
    step4("t5_rsst", 1, 1, 3'b000, 0, 4'hF, 1, 4'b0000, 0, 0);
    step4("t5_idle", 0, 0, 3'b000, 0, 4'h0, 0, 4'b0000, 0, 0);
    step4("t5_st2",  0, 1, 3'b000, 0, 4'h9, 1, 4'b1001, 1, 0);
    step4("t5_b1",   0, 1, 3'b000, 0, 4'h0, 0, 4'b0100, 1, 0);
    step4("t5_b2",   0, 1, 3'b000, 0, 4'h0, 0, 4'b0010, 1, 0);
    step4("t5_b3",   0, 1, 3'b000, 0, 4'h0, 0, 4'b0001, 1, 0);
    step4("t5_b4",   0, 1, 3'b000, 0, 4'h0, 0, 4'b0000, 0, 1);
    // 6: WIDTH=8 reset value, back-to-back bursts with start held
    step8("t6_rst",  1, 0, 0, 8'h00, 0, 8'hA5, 0, 0);
    step8("t6_idle", 0, 0, 0, 8'h00, 0, 8'hA5, 0, 0);
    for (int b = 0; b < 2; b++) begin
      w = 8'h3C;
      step8("t6_st", 0, 1, 0, 8'h3C, 1, w, 1, 0);
      for (int i = 1; i < 8; i++) begin
        w = w >> 1;
        step8("t6_b", 0, 1, 0, 8'h3C, 1, w, 1, 0);
      end
      // final shift; start still high, so the done cycle is followed by a relaunch
      step8("t6_dn", 0, 1, 0, 8'h3C, b == 0, 8'h00, 0, 1);
    end
    step8("t6_end", 0, 1, 0, 8'h3C, 0, 8'h00, 0, 0);

    repeat (3) @(posedge clk);
    #2;
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/shift_reg_n.md
# shift_reg_n

Parametrised N-bit universal shift register, the successor to the fixed 4-bit serial shift register. Adds synchronous reset, clock enable, bidirectional shift, rotate and parallel load. Also adds a self-timed burst mode: a captured word is serialised LSB-first over exactly WIDTH enabled cycles, with busy/done status. Sits between parallel producers and single-bit serial links, or chains as a plain serial delay line.

## Interface
- WIDTH, 8, register length in bits; legal range ≥ 2.
- RESET_VALUE, {WIDTH{1'b0}}, contents of q after reset.

- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; one clock and one synchronous active-high reset, no other clocks or async resets.
- enable  in  1  clock enable for mode operations and burst shifting.
- mode  in  3  operation select, sampled each edge while idle.
- shift_in  in  1  serial input bit.
- load_data  in  WIDTH  parallel load / burst source word.
- start  in  1  request a burst; sampled only while idle.
- q  out  WIDTH  register contents.
- shift_out_lsb  out  1  q[0], combinational from q.
- shift_out_msb  out  1  q[WIDTH-1], combinational from q.
- busy  out  1  high while a burst is in progress.
- done  out  1  one-cycle pulse after a burst's last shift.

## Operation
- Two states: IDLE and BURST. A down-counter cnt is $clog2(WIDTH+1) bits wide.
- On reset: q=RESET_VALUE, state=IDLE, cnt=0, busy=0, done=0. Reset overrides every other input, including a burst in progress.
- IDLE, start=1: capture the burst regardless of enable or mode.
  - q<=load_data, cnt<=WIDTH, state<=BURST.
- IDLE, start=0, enable=1: act on mode.
  - 000 hold: no change.
  - 001 shift right: q<={shift_in, q[W-1:1]}.
  - 010 shift left: q<={q[W-2:0], shift_in}.
  - 011 rotate right: q<={q[0], q[W-1:1]}.
  - 100 rotate left: q<={q[W-2:0], q[W-1]}.
  - 101 parallel load: q<=load_data.
  - 110 and 111: reserved, behave as hold.
- IDLE, start=0, enable=0: q holds, whatever the mode.
- BURST, enable=1: shift right with shift_in entering the MSB, and cnt<=cnt-1.
  - If cnt==1 at that edge: state<=IDLE, and done is 1 for the next cycle.
- BURST, enable=0: stall. q and cnt hold; no timeout.
- BURST ignores mode and start. A start held high across the end of a burst launches a new burst on the first IDLE cycle; back-to-back bursts are legal.
- busy = (state==BURST), registered.
- done is registered and high for exactly one cycle, the first IDLE cycle after a burst. It is 0 at all other times.

## Timing
- Mode operations take effect in q one cycle after the sampling edge.
- Burst, start sampled at edge k with enable held high through edge k+W:
  - Cycles after edges k..k+W-1: busy=1, and shift_out_lsb = load_data[0], load_data[1], …, load_data[W-1] in that order, one bit per cycle.
  - After edge k+W: busy=0, done=1 for one cycle. q then equals the last W shift_in bits, the newest at the MSB.
- Each enable=0 cycle during a burst stretches busy by one cycle and delays done by one cycle.
- Reset asserted mid-burst: on the next edge busy=0, no done pulse, and q=RESET_VALUE.
- Start asserted in the same cycle as reset: ignored.

## Test plan
Run with WIDTH=4, RESET_VALUE=0 unless stated otherwise.
1. Reset, then mode=001, enable=1, shift_in pattern 1,0,0,0,0 -> q=1000, 0100, 0010, 0001, 0000. shift_out_lsb goes high in cycle 4 only.
2. mode=101 with load_data=1011, then mode=011 for 4 cycles -> q=1101, 1110, 0111, 1011. Then mode=100 for 1 cycle -> q=0111.
3. start with load_data=1010, enable=1, shift_in=0 -> busy high 4 cycles, shift_out_lsb=0,1,0,1, then done=1 for one cycle with q=0000.
4. Burst as in 3 with enable=0 for 2 cycles mid-burst -> busy high 6 cycles, same serial bit order, done delayed by 2 cycles. A mode=101 request applied during the burst has no effect.
5. Reset asserted in the 2nd burst cycle -> next cycle q=0000, busy=0, done never pulses. A start applied afterwards launches a fresh burst normally.
6. WIDTH=8, RESET_VALUE=8'hA5: reset -> q=A5. With start held high and load_data=8'h3C -> two bursts of 8 busy cycles each, separated by one IDLE cycle with done=1.
